// File: rtl/analog_dir_pkg.sv
// Shared types and defaults for the analog-stick direction encoder.
// Axis states, threshold/debounce defaults and the signed-to-magnitude helper.
package analog_dir_pkg;

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        POS     = 2'd1,
        NEG     = 2'd2
    } axis_state_t;

    localparam int T_ON_DEFAULT  = 48;
    localparam int T_OFF_DEFAULT = 32;
    localparam int DEB_DEFAULT   = 3;

    // Unsigned 8-bit magnitude of a two's complement byte; -128 maps to 128.
    function automatic logic [7:0] axis_magnitude(input logic [7:0] value);
        axis_magnitude = value[7] ? (8'd0 - value) : value;
    endfunction

endpackage

// File: rtl/analog_axis_filter.sv
// One stick axis: hysteresis classification followed by a strobe-driven debounce.
// Reports the committed state; filtering only advances on ce_sample.
module analog_axis_filter
    import analog_dir_pkg::*;
#(
    parameter int T_ON  = T_ON_DEFAULT,
    parameter int T_OFF = T_OFF_DEFAULT,
    parameter int DEB   = DEB_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_sample,
    input  logic [7:0] sample,
    output logic [1:0] state
);

    localparam logic [7:0] T_ON_U  = 8'(T_ON);
    localparam logic [7:0] T_OFF_U = 8'(T_OFF);
    localparam logic [3:0] DEB_U   = 4'(DEB);

    axis_state_t committed_r;
    axis_state_t pending_r;
    logic [3:0]  cnt_r;

    axis_state_t candidate_s;
    logic [7:0]  mag_s;
    logic        is_pos_s;
    logic        is_neg_s;
    logic        pos_on_s;
    logic        neg_on_s;
    logic        pos_hold_s;
    logic        neg_hold_s;
    logic [3:0]  cnt_inc_s;

    assign mag_s      = axis_magnitude(sample);
    assign is_neg_s   = sample[7];
    assign is_pos_s   = !sample[7] && (sample != 8'd0);
    assign pos_on_s   = is_pos_s && (mag_s >= T_ON_U);
    assign neg_on_s   = is_neg_s && (mag_s >= T_ON_U);
    assign pos_hold_s = is_pos_s && (mag_s > T_OFF_U);
    assign neg_hold_s = is_neg_s && (mag_s > T_OFF_U);
    assign cnt_inc_s  = (cnt_r == 4'hF) ? cnt_r : (cnt_r + 4'd1);

    // Hysteresis: leaving neutral needs T_ON, staying deflected needs more than T_OFF.
    always_comb begin
        candidate_s = NEUTRAL;
        case (committed_r)
            NEUTRAL: begin
                if (pos_on_s)      candidate_s = POS;
                else if (neg_on_s) candidate_s = NEG;
                else               candidate_s = NEUTRAL;
            end
            POS: begin
                if (pos_hold_s)    candidate_s = POS;
                else if (neg_on_s) candidate_s = NEG;
                else               candidate_s = NEUTRAL;
            end
            NEG: begin
                if (neg_hold_s)    candidate_s = NEG;
                else if (pos_on_s) candidate_s = POS;
                else               candidate_s = NEUTRAL;
            end
            default: candidate_s = NEUTRAL;
        endcase
    end

    // Debounce: a differing candidate must repeat DEB strobes in a row before commit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            committed_r <= NEUTRAL;
            pending_r   <= NEUTRAL;
            cnt_r       <= 4'd0;
        end else if (ce_sample) begin
            if (candidate_s == committed_r) begin
                cnt_r <= 4'd0;
            end else if (candidate_s == pending_r) begin
                if (cnt_inc_s >= DEB_U) begin
                    committed_r <= pending_r;
                    cnt_r       <= 4'd0;
                end else begin
                    cnt_r <= cnt_inc_s;
                end
            end else begin
                pending_r <= candidate_s;
                if (DEB_U <= 4'd1) begin
                    committed_r <= candidate_s;
                    cnt_r       <= 4'd0;
                end else begin
                    cnt_r <= 4'd1;
                end
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign state = committed_r;

endmodule

// File: rtl/analog_dir_encoder.sv
// Analog stick to 4-way direction encoder with a digital bypass.
// Two axis filters feed a registered {up,down,left,right} output and change pulse.
module analog_dir_encoder
    import analog_dir_pkg::*;
#(
    parameter int T_ON  = T_ON_DEFAULT,
    parameter int T_OFF = T_OFF_DEFAULT,
    parameter int DEB   = DEB_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_sample,
    input  logic [15:0] analog,
    input  logic        sel_digital,
    input  logic [3:0]  dig_in,
    output logic [3:0]  dir,
    output logic        dir_changed
);

    logic [1:0] x_state_s;
    logic [1:0] y_state_s;
    logic [3:0] filt_dir_s;
    logic [3:0] dir_next_s;
    logic [3:0] dir_r;
    logic       dir_changed_r;

    analog_axis_filter #(.T_ON(T_ON), .T_OFF(T_OFF), .DEB(DEB)) u_axis_x (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_sample (ce_sample),
        .sample    (analog[7:0]),
        .state     (x_state_s)
    );

    analog_axis_filter #(.T_ON(T_ON), .T_OFF(T_OFF), .DEB(DEB)) u_axis_y (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_sample (ce_sample),
        .sample    (analog[15:8]),
        .state     (y_state_s)
    );

    // A single committed state per axis keeps opposite directions mutually exclusive.
    assign filt_dir_s = {y_state_s == NEG, y_state_s == POS,
                         x_state_s == NEG, x_state_s == POS};
    assign dir_next_s = sel_digital ? dig_in : filt_dir_s;

    // Output register; the change pulse rises in the same cycle the new dir appears.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dir_r         <= 4'b0000;
            dir_changed_r <= 1'b0;
        end else begin
            dir_r         <= dir_next_s;
            dir_changed_r <= (dir_next_s != dir_r);
        end
    end

    assign dir         = dir_r;
    assign dir_changed = dir_changed_r;

endmodule

// File: doc/analog_dir_encoder.md
ANALOG_DIR_ENCODER -- requirements
Module: analog_dir_encoder

Interface
REQ-001 Parameter T_ON, default 48, 7-bit axis magnitude at which a neutral axis leaves neutral (1..127).
REQ-002 Parameter T_OFF, default 32, 7-bit axis magnitude below which a deflected axis returns to neutral (0..T_ON).
REQ-003 Parameter DEB, default 3, number of consecutive sample strobes a new axis state must persist before commit (1..15).
REQ-004 clk_sys  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce_sample  in  1  one-cycle sample strobe; all filtering advances only on cycles with ce_sample=1.
REQ-007 analog  in  16  stick sample; [7:0] X signed two's complement, [15:8] Y signed; negative X = left, negative Y = up.
REQ-008 sel_digital  in  1  1 = bypass filter, drive dir from dig_in.
REQ-009 dig_in  in  4  digital direction {up,down,left,right}.
REQ-010 dir  out  4  filtered direction {up,down,left,right}, registered.
REQ-011 dir_changed  out  1  one-cycle pulse when dir takes a new value.

Function
REQ-012 Each axis (X, Y) SHALL hold a committed state in {NEUTRAL, POS, NEG}, processed independently and identically.
REQ-013 Axis magnitude SHALL be computed with 8-bit unsigned result so that -128 yields 128 (no overflow to negative).
REQ-014 Candidate from NEUTRAL: value >= +T_ON -> POS; value <= -T_ON -> NEG; else NEUTRAL.
REQ-015 Candidate from POS: value > +T_OFF -> POS; value <= -T_ON -> NEG; else NEUTRAL (mirror for NEG).
REQ-016 On ce_sample, if candidate == committed the axis debounce counter SHALL clear to 0.
REQ-017 On ce_sample, if candidate != committed and candidate equals the pending candidate, counter SHALL increment; if it differs from the pending candidate, pending SHALL be loaded and counter set to 1.
REQ-018 Committed state SHALL update to pending on the ce_sample where the counter reaches DEB, and counter SHALL then clear; DEB=1 commits on the first differing sample.
REQ-019 Counter SHALL saturate and never wrap; cycles without ce_sample SHALL leave all state unchanged.
REQ-020 dir filtered mapping: right=X POS, left=X NEG, down=Y POS, up=Y NEG; left&right and up&down SHALL never both be 1.
REQ-021 dir SHALL reflect a commit on the clock edge following the committing ce_sample cycle (1-cycle latency).
REQ-022 With sel_digital=1, dir SHALL equal dig_in registered one cycle, independent of ce_sample; axis filter state continues to run.
REQ-023 Changing sel_digital SHALL switch dir source on the next clock edge with no additional filtering.
REQ-024 dir_changed SHALL be 1 for exactly the cycle in which dir differs from its previous registered value.

Reset
REQ-025 On reset: both axes NEUTRAL, pending NEUTRAL, counters 0, dir=4'b0000, dir_changed=0.
REQ-026 Reset asserted mid-debounce SHALL discard pending progress; reset has priority over ce_sample in the same cycle.
REQ-027 After reset deasserts, a held deflection SHALL require a full DEB samples to appear on dir.

Structure
REQ-028 Package analog_dir_pkg SHALL hold the axis_state_t enum (NEUTRAL, POS, NEG) and default T_ON/T_OFF/DEB constants.
REQ-029 One sub-module analog_axis_filter (hysteresis + debounce for one signed 8-bit axis) SHALL be instantiated twice.
REQ-030 Output mux, dir register and dir_changed logic SHALL live in the top module.

Verification
REQ-031 DEB=3, X=+60 held, strobe every 4 clocks -> dir=0001 one clock after 3rd strobe; dir_changed pulses once.
REQ-032 X committed POS, X=+40 for 5 strobes -> stays 0001; X=+32 for 3 strobes -> dir=0000 (hysteresis at T_OFF).
REQ-033 X=-128, Y=-128 held 3 strobes -> dir=1010 (up+left), no overflow.
REQ-034 X=+60 for 2 strobes, +10 for 1 strobe, +60 for 2 strobes -> dir stays 0000 (counter restarts on candidate change).
REQ-035 Reset asserted after 2 of 3 debounce strobes -> dir=0000; 3 further strobes required before dir=0001.
REQ-036 sel_digital=1, dig_in=0100 -> dir=0100 next cycle with no ce_sample; sel_digital=0 with axes neutral -> dir=0000 next cycle.
